// File: rtl/fc_irq_arbiter.sv
// fc_irq_arbiter
//   Interrupt arbiter for the FC core. It latches rising edges on the IRQ
//   lines and queues event IDs in a small FIFO. The FIFO non-empty state is
//   the level source for line EVT_IRQ_LINE. Pending lines are masked, and the
//   lowest eligible index is presented to the core both as an ID and as a
//   one-hot vector.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   irq_lines_i         level IRQ sources (bit EVT_IRQ_LINE ignored)
//   evt_valid_i/_ready_o/evt_data_i   event push interface
//   cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, cfg_rdata_o
//                       register access: 0 MASK, 1 PENDING, 2 PEND_CLR, 3 EVT_HEAD
//   core_irq_req_o, core_irq_id_o, core_irq_x_o   request towards the core
//   core_irq_ack_i, core_irq_ack_id_i             acknowledge from the core
//
// Handshake: an event is pushed on any rising clock edge where evt_valid_i
// and evt_ready_o are both high. evt_ready_o depends only on FIFO occupancy
// and never on evt_valid_i. A producer holds valid and data until it sees
// ready.
module fc_irq_arbiter #(
    parameter int NB_IRQ         = 32,
    parameter int EVT_ID_WIDTH   = 8,
    parameter int EVT_FIFO_DEPTH = 4,
    parameter int EVT_IRQ_LINE   = 26,
    parameter int IRQ_ID_WIDTH   = $clog2(NB_IRQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NB_IRQ-1:0]       irq_lines_i,
    input  logic                    evt_valid_i,
    output logic                    evt_ready_o,
    input  logic [EVT_ID_WIDTH-1:0] evt_data_i,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [1:0]              cfg_addr_i,
    input  logic [NB_IRQ-1:0]       cfg_wdata_i,
    output logic [NB_IRQ-1:0]       cfg_rdata_o,
    output logic                    core_irq_req_o,
    output logic [IRQ_ID_WIDTH-1:0] core_irq_id_o,
    output logic [NB_IRQ-1:0]       core_irq_x_o,
    input  logic                    core_irq_ack_i,
    input  logic [IRQ_ID_WIDTH-1:0] core_irq_ack_id_i
);

    localparam int PTR_W = $clog2(EVT_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [NB_IRQ-1:0] EVT_BIT = {{(NB_IRQ-1){1'b0}}, 1'b1} << EVT_IRQ_LINE;

    logic [NB_IRQ-1:0]       mask_q, mask_d;
    logic [NB_IRQ-1:0]       pend_q, pend_d;
    logic [NB_IRQ-1:0]       prev_q;
    logic [EVT_ID_WIDTH-1:0] fifo_q [EVT_FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic [IRQ_ID_WIDTH-1:0] id_q, id_d;
    logic [NB_IRQ-1:0]       x_q, x_d;
    logic [NB_IRQ-1:0]       rdata_q, rdata_d;

    logic                    fifo_empty, fifo_full, push, pop;
    logic                    cfg_wr, cfg_rd;
    logic [NB_IRQ-1:0]       pend_vis, eligible, edge_v, clr_v, head_ext;
    logic [NB_IRQ+EVT_ID_WIDTH-1:0] head_wide;
    logic                    win_found;
    logic [IRQ_ID_WIDTH-1:0] win_id;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(EVT_FIFO_DEPTH));
    assign push       = evt_valid_i & ~fifo_full;
    assign pop        = core_irq_ack_i & ~fifo_empty &
                        (core_irq_ack_id_i == IRQ_ID_WIDTH'(EVT_IRQ_LINE));
    assign cfg_wr     = cfg_req_i & cfg_we_i;
    assign cfg_rd     = cfg_req_i & ~cfg_we_i;

    // The event line has no latch: its pending bit mirrors FIFO occupancy.
    assign pend_vis = (pend_q & ~EVT_BIT) | (fifo_empty ? '0 : EVT_BIT);
    assign eligible = pend_vis & mask_q;

    // Lowest set index wins. Scanning downward lets the last hit be the lowest.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_id    = IRQ_ID_WIDTH'(i);
            end
        end
    end

    assign edge_v    = irq_lines_i & ~prev_q & ~EVT_BIT;
    assign head_wide = {{NB_IRQ{1'b0}}, fifo_q[rd_ptr_q]};
    assign head_ext  = fifo_empty ? '0 : head_wide[NB_IRQ-1:0];

    always_comb begin
        clr_v = '0;
        if (core_irq_ack_i) begin
            clr_v = clr_v | ({{(NB_IRQ-1){1'b0}}, 1'b1} << core_irq_ack_id_i);
        end
        if (cfg_wr && cfg_addr_i == 2'd2) begin
            clr_v = clr_v | cfg_wdata_i;
        end
        // Edges are ORed in after clearing, so an edge in the same cycle wins.
        pend_d = ((pend_q & ~clr_v) | edge_v) & ~EVT_BIT;

        mask_d = mask_q;
        if (cfg_wr && cfg_addr_i == 2'd0) begin
            mask_d = cfg_wdata_i;
        end

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        rdata_d = rdata_q;
        if (cfg_rd) begin
            case (cfg_addr_i)
                2'd0:    rdata_d = mask_q;
                2'd1:    rdata_d = pend_vis;
                2'd3:    rdata_d = head_ext;
                default: rdata_d = '0;
            endcase
        end

        // Hold-off: the cycle after an ack never requests. This gives the
        // cleared pending bit time to reach the arbiter before it re-evaluates.
        req_d = win_found & ~core_irq_ack_i;
        id_d  = req_d ? win_id : '0;
        x_d   = req_d ? ({{(NB_IRQ-1){1'b0}}, 1'b1} << win_id) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q   <= '0;
            pend_q   <= '0;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            id_q     <= '0;
            x_q      <= '0;
            rdata_q  <= '0;
        end else begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            prev_q  <= irq_lines_i;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            id_q    <= id_d;
            x_q     <= x_d;
            rdata_q <= rdata_d;
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= evt_data_i;
    end

    assign evt_ready_o    = ~fifo_full;
    assign cfg_rdata_o    = rdata_q;
    assign core_irq_req_o = req_q;
    assign core_irq_id_o  = id_q;
    assign core_irq_x_o   = x_q;

endmodule

// File: tb/tb_fc_irq_arbiter.sv
module tb_fc_irq_arbiter;
  localparam int NB = 32;
  localparam int IDW = 5;
  localparam int EVT = 26;
  localparam int DEPTH = 4;
  localparam int W = 1 + IDW + NB + 1 + NB;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NB-1:0]  lines;
  logic           evt_valid, evt_ready;
  logic [7:0]     evt_data;
  logic           cfg_req, cfg_we;
  logic [1:0]     cfg_addr;
  logic [NB-1:0]  cfg_wdata, cfg_rdata;
  logic           req;
  logic [IDW-1:0] id;
  logic [NB-1:0]  x;
  logic           ack;
  logic [IDW-1:0] ack_id;

  fc_irq_arbiter dut (
    .clk_i(clk), .rst_i(rst), .irq_lines_i(lines),
    .evt_valid_i(evt_valid), .evt_ready_o(evt_ready), .evt_data_i(evt_data),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(cfg_rdata),
    .core_irq_req_o(req), .core_irq_id_o(id), .core_irq_x_o(x),
    .core_irq_ack_i(ack), .core_irq_ack_id_i(ack_id)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending set, FIFO as a queue, outputs from priority rules
  logic [NB-1:0]  m_mask, m_pend, m_prev, m_rdata;
  logic [7:0]     m_fifo[$];
  logic [W-1:0]   exp_q[$];

  always @(posedge clk) begin : model
    logic [NB-1:0]  vis, elig, edges, e_x;
    logic           e_req, e_rdy, do_push, do_pop;
    logic [IDW-1:0] e_id;
    logic [7:0]     dummy;
    if (rst) begin
      m_mask = '0; m_pend = '0; m_prev = '0; m_rdata = '0;
      m_fifo.delete();
      exp_q.push_back({1'b0, {IDW{1'b0}}, {NB{1'b0}}, 1'b1, {NB{1'b0}}});
    end else begin
      vis = m_pend;
      vis[EVT] = (m_fifo.size() != 0);
      elig = vis & m_mask;
      e_req = 1'b0;
      e_id = '0;
      if (!ack) begin
        for (int i = 0; i < NB; i++) begin
          if (elig[i]) begin
            e_req = 1'b1;
            e_id = IDW'(i);
            break;
          end
        end
      end
      e_x = e_req ? (32'd1 << e_id) : 32'd0;
      if (cfg_req && !cfg_we) begin
        case (cfg_addr)
          2'd0: m_rdata = m_mask;
          2'd1: m_rdata = vis;
          2'd2: m_rdata = '0;
          default: m_rdata = (m_fifo.size() != 0) ? {24'd0, m_fifo[0]} : 32'd0;
        endcase
      end
      edges = lines & ~m_prev;
      edges[EVT] = 1'b0;
      if (ack) m_pend[ack_id] = 1'b0;
      if (cfg_req && cfg_we && cfg_addr == 2'd2) m_pend = m_pend & ~cfg_wdata;
      m_pend = m_pend | edges;
      if (cfg_req && cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
      do_push = evt_valid && (m_fifo.size() < DEPTH);
      do_pop = ack && (ack_id == IDW'(EVT)) && (m_fifo.size() != 0);
      if (do_pop) dummy = m_fifo.pop_front();
      if (do_push) m_fifo.push_back(evt_data);
      m_prev = lines;
      e_rdy = (m_fifo.size() < DEPTH);
      exp_q.push_back({e_req, e_id, e_x, e_rdy, m_rdata});
    end
  end

  // monitor: the DUT presents a full output set after every edge
  always @(posedge clk) begin : monitor
    logic [W-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("req", {63'd0, req}, {63'd0, e[W-1]});
      chk("id", {59'd0, id}, {59'd0, e[W-2 -: IDW]});
      chk("irq_x", {32'd0, x}, {32'd0, e[W-2-IDW -: NB]});
      chk("ready", {63'd0, evt_ready}, {63'd0, e[NB]});
      chk("rdata", {32'd0, cfg_rdata}, {32'd0, e[NB-1:0]});
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; evt_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [NB-1:0] d);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
  endtask

  task automatic cfg_read(input logic [1:0] a);
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
  endtask

  task automatic do_ack(input int n);
    ack = 1'b1; ack_id = IDW'(n);
  endtask

  logic [7:0] vals [4];

  initial begin
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rst = 1'b1; lines = '0; evt_valid = 1'b0; evt_data = '0;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ack = 1'b0; ack_id = '0;
    repeat (3) tick;
    chk("rst_req", {63'd0, req}, 64'd0);
    chk("rst_ready", {63'd0, evt_ready}, 64'd1);
    rst = 1'b0;

    // 1: single edge, ack
    cfg_write(2'd0, 32'hFFFF_FFFF); tick;
    lines[5] = 1'b1; tick; tick;
    chk("t1_req", {63'd0, req}, 64'd1);
    chk("t1_id", {59'd0, id}, 64'd5);
    chk("t1_x", {32'd0, x}, 64'h20);
    do_ack(5); tick;
    chk("t1_req_ack", {63'd0, req}, 64'd0);
    cfg_read(2'd1); tick;
    chk("t1_pend5", {63'd0, cfg_rdata[5]}, 64'd0);
    lines = '0;

    // 2: simultaneous edges, bubble after ack
    lines[3] = 1'b1; lines[9] = 1'b1; tick; tick;
    chk("t2_id3", {59'd0, id}, 64'd3);
    do_ack(3); tick;
    chk("t2_bubble", {63'd0, req}, 64'd0);
    tick;
    chk("t2_req9", {63'd0, req}, 64'd1);
    chk("t2_id9", {59'd0, id}, 64'd9);
    do_ack(9); tick;
    lines = '0; tick;

    // 3: fill FIFO, backpressure, head
    for (int k = 0; k < 4; k++) begin
      evt_valid = 1'b1; evt_data = vals[k]; tick;
    end
    chk("t3_full", {63'd0, evt_ready}, 64'd0);
    evt_valid = 1'b1; evt_data = 8'hE5; tick;
    evt_valid = 1'b1; tick;
    cfg_read(2'd3); tick;
    chk("t3_head_a1", {32'd0, cfg_rdata}, 64'hA1);
    do_ack(EVT); tick;
    chk("t3_ready", {63'd0, evt_ready}, 64'd1);
    cfg_read(2'd3); tick;
    chk("t3_head_b2", {32'd0, cfg_rdata}, 64'hB2);

    // 4: push+pop same cycle, drain
    do_ack(EVT); tick;
    evt_valid = 1'b1; evt_data = 8'h55; do_ack(EVT); tick;
    cfg_read(2'd3); tick;
    chk("t4_head_d4", {32'd0, cfg_rdata}, 64'hD4);
    do_ack(EVT); tick;
    cfg_read(2'd3); tick;
    chk("t4_head_55", {32'd0, cfg_rdata}, 64'h55);
    do_ack(EVT); tick;
    tick;
    cfg_read(2'd1); tick;
    chk("t4_pend26", {63'd0, cfg_rdata[EVT]}, 64'd0);
    chk("t4_req", {63'd0, req}, 64'd0);

    // 5: PEND_CLR racing an edge, then mask off
    lines[7] = 1'b1; cfg_write(2'd2, 32'h80); tick;
    cfg_read(2'd1); tick;
    chk("t5_pend7", {63'd0, cfg_rdata[7]}, 64'd1);
    cfg_write(2'd0, 32'h0); tick; tick;
    chk("t5_req_masked", {63'd0, req}, 64'd0);
    cfg_read(2'd1); tick;
    chk("t5_pend7_kept", {63'd0, cfg_rdata[7]}, 64'd1);
    lines = '0;

    // 6: reset mid-request
    cfg_write(2'd0, 32'hFFFF_FFFF); tick;
    for (int k = 0; k < 3; k++) begin
      evt_valid = 1'b1; evt_data = vals[k]; tick;
    end
    lines[12] = 1'b1; tick;
    rst = 1'b1; tick;
    chk("t6_req", {63'd0, req}, 64'd0);
    chk("t6_id", {59'd0, id}, 64'd0);
    chk("t6_x", {32'd0, x}, 64'd0);
    chk("t6_ready", {63'd0, evt_ready}, 64'd1);
    chk("t6_rdata", {32'd0, cfg_rdata}, 64'd0);
    rst = 1'b0; tick;
    cfg_read(2'd1); tick;
    chk("t6_repend12", {63'd0, cfg_rdata[12]}, 64'd1);
    chk("t6_pend26", {63'd0, cfg_rdata[EVT]}, 64'd0);
    lines = '0; tick;

    // random phase
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 15) == 0) lines[b] = ~lines[b];
      end
      evt_valid = ($urandom_range(0, 2) == 0);
      evt_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ack = 1'b1;
        case ($urandom_range(0, 3))
          0, 1: ack_id = id;
          2: ack_id = IDW'(EVT);
          default: ack_id = IDW'($urandom_range(0, NB - 1));
        endcase
      end
      if ($urandom_range(0, 4) == 0) begin
        cfg_req = 1'b1;
        cfg_we = 1'($urandom_range(0, 1));
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_wdata = (cfg_addr == 2'd0) ? ($urandom | $urandom) : $urandom;
      end
      tick;
    end
    rst = 1'b0;
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
